// File: rtl/pm_tap_ctrl_if.sv
// rtl/pm_tap_ctrl_if.sv - TAP-side signal bundle between a JTAG front end and pm_tap_ctrl
interface pm_tap_ctrl_if #(
    parameter int IR_LENGTH = 4
);
    logic                 tck_en;
    logic                 tms;
    logic                 tdi;
    logic                 stat_tdo;
    logic                 ctrl_tdo;
    logic                 capture_dr;
    logic                 shift_dr;
    logic                 update_dr;
    logic                 sel_stat;
    logic                 sel_ctrl;
    logic                 stat_read;
    logic [IR_LENGTH-1:0] ir;
    logic                 tdo;
    logic                 tdo_en;

    modport master (
        output tck_en, tms, tdi, stat_tdo, ctrl_tdo,
        input  capture_dr, shift_dr, update_dr, sel_stat, sel_ctrl, stat_read, ir, tdo, tdo_en
    );

    modport slave (
        input  tck_en, tms, tdi, stat_tdo, ctrl_tdo,
        output capture_dr, shift_dr, update_dr, sel_stat, sel_ctrl, stat_read, ir, tdo, tdo_en
    );
endinterface

// File: rtl/pm_tap_ctrl.sv
// rtl/pm_tap_ctrl.sv - IEEE 1149.1 TAP controller with status/control/bypass data registers
module pm_tap_ctrl #(
    parameter int                   IR_LENGTH   = 4,
    parameter logic [IR_LENGTH-1:0] STAT_OPCODE = IR_LENGTH'('h2),
    parameter logic [IR_LENGTH-1:0] CTRL_OPCODE = IR_LENGTH'('h3)
) (
    input  logic          clk,
    input  logic          rst,
    pm_tap_ctrl_if.slave  tap
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_LENGTH-1:0] IR_CAPTURE = IR_LENGTH'(1);

    tap_state_e           state;
    tap_state_e           state_nxt;
    logic [IR_LENGTH-1:0] ir_sh;
    logic [IR_LENGTH-1:0] ir_reg;
    logic [IR_LENGTH-1:0] ir_cur;
    logic                 byp;
    logic                 sel_stat;
    logic                 sel_ctrl;
    logic                 sel_byp;
    logic                 act;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TLR;
        end else if (tap.tck_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:                 state_nxt = tap.tms ? TLR    : RTI;
            RTI, UPD_DR, UPD_IR: state_nxt = tap.tms ? SEL_DR : RTI;
            SEL_DR:              state_nxt = tap.tms ? SEL_IR : CAP_DR;
            SEL_IR:              state_nxt = tap.tms ? TLR    : CAP_IR;
            CAP_DR, SH_DR:       state_nxt = tap.tms ? EX1_DR : SH_DR;
            EX1_DR:              state_nxt = tap.tms ? UPD_DR : PA_DR;
            PA_DR:               state_nxt = tap.tms ? EX2_DR : PA_DR;
            EX2_DR:              state_nxt = tap.tms ? UPD_DR : SH_DR;
            CAP_IR, SH_IR:       state_nxt = tap.tms ? EX1_IR : SH_IR;
            EX1_IR:              state_nxt = tap.tms ? UPD_IR : PA_IR;
            PA_IR:               state_nxt = tap.tms ? EX2_IR : PA_IR;
            EX2_IR:              state_nxt = tap.tms ? UPD_IR : SH_IR;
            default:             state_nxt = TLR;
        endcase
    end

    // Instruction and bypass datapath; everything except the TLR override waits for a TCK strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_sh  <= '1;
            ir_reg <= '1;
            byp    <= 1'b0;
        end else begin
            if (state == TLR) begin
                ir_reg <= '1;
            end else if (tap.tck_en && state == UPD_IR) begin
                ir_reg <= ir_sh;
            end
            if (tap.tck_en) begin
                if (state == CAP_IR) begin
                    ir_sh <= IR_CAPTURE;
                end else if (state == SH_IR) begin
                    ir_sh <= {tap.tdi, ir_sh[IR_LENGTH-1:1]};
                end
            end
            if (tap.tck_en && sel_byp) begin
                if (state == CAP_DR) begin
                    byp <= 1'b0;
                end else if (state == SH_DR) begin
                    byp <= tap.tdi;
                end
            end
        end
    end

    // TLR forces BYPASS immediately, not one clk later when ir_reg catches up.
    always_comb begin
        ir_cur   = (state == TLR) ? '1 : ir_reg;
        sel_stat = (ir_cur == STAT_OPCODE);
        sel_ctrl = (ir_cur == CTRL_OPCODE);
        sel_byp  = !(sel_stat || sel_ctrl);
        act      = !rst && tap.tck_en;
    end

    always_comb begin
        tap.ir         = ir_cur;
        tap.sel_stat   = sel_stat;
        tap.sel_ctrl   = sel_ctrl;
        tap.capture_dr = act && (state == CAP_DR) && !sel_byp;
        tap.shift_dr   = act && (state == SH_DR)  && !sel_byp;
        tap.update_dr  = act && (state == UPD_DR) && !sel_byp;
        tap.stat_read  = act && (state == UPD_DR) && sel_stat;
        tap.tdo        = 1'b0;
        tap.tdo_en     = 1'b0;
        if (!rst) begin
            case (state)
                SH_IR: begin
                    tap.tdo    = ir_sh[0];
                    tap.tdo_en = 1'b1;
                end
                SH_DR: begin
                    tap.tdo    = sel_stat ? tap.stat_tdo : (sel_ctrl ? tap.ctrl_tdo : byp);
                    tap.tdo_en = 1'b1;
                end
                default: begin
                    tap.tdo    = 1'b0;
                    tap.tdo_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_tap_ctrl.sv
// tb/tb_pm_tap_ctrl.sv - randomized model-checked bench for pm_tap_ctrl
module tb_pm_tap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pm_tap_ctrl_if #(.IR_LENGTH(4)) tap();

    pm_tap_ctrl #(.IR_LENGTH(4), .STAT_OPCODE(4'h2), .CTRL_OPCODE(4'h3)) dut (
        .clk (clk),
        .rst (rst),
        .tap (tap)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state numbering: 0 TLR 1 RTI 2 SEL_DR 3 CAP_DR 4 SH_DR 5 EX1_DR 6 PA_DR 7 EX2_DR
    // 8 UPD_DR 9 SEL_IR 10 CAP_IR 11 SH_IR 12 EX1_IR 13 PA_IR 14 EX2_IR 15 UPD_IR
    localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int         m_st  = 0;
    logic [3:0] m_ir  = 4'hF;
    logic [3:0] m_sh  = 4'hF;
    logic       m_byp = 1'b0;

    function automatic logic [3:0] m_eff_ir();
        return (m_st == 0) ? 4'hF : m_ir;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_ir = 4'hF; m_sh = 4'hF; m_byp = 1'b0;
        end else begin
            logic [3:0] e;
            e = m_eff_ir();
            if (m_st == 0) m_ir = 4'hF;
            if (tap.tck_en) begin
                if (m_st == 10) m_sh = 4'b0001;
                if (m_st == 11) m_sh = {tap.tdi, m_sh[3:1]};
                if (m_st == 15) m_ir = m_sh;
                if (e != 4'h2 && e != 4'h3) begin
                    if (m_st == 3) m_byp = 1'b0;
                    if (m_st == 4) m_byp = tap.tdi;
                end
                m_st = tap.tms ? NXT1[m_st] : NXT0[m_st];
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            logic [3:0] e;
            logic a, ss, sc, et;
            e  = m_eff_ir();
            a  = !rst && tap.tck_en;
            ss = (e == 4'h2);
            sc = (e == 4'h3);
            et = 1'b0;
            if (!rst && m_st == 11) et = m_sh[0];
            if (!rst && m_st == 4)  et = ss ? tap.stat_tdo : (sc ? tap.ctrl_tdo : m_byp);
            chk("ir",         tap.ir,         e);
            chk("sel_stat",   tap.sel_stat,   ss);
            chk("sel_ctrl",   tap.sel_ctrl,   sc);
            chk("capture_dr", tap.capture_dr, a && m_st == 3 && (ss || sc));
            chk("shift_dr",   tap.shift_dr,   a && m_st == 4 && (ss || sc));
            chk("update_dr",  tap.update_dr,  a && m_st == 8 && (ss || sc));
            chk("stat_read",  tap.stat_read,  a && m_st == 8 && ss);
            chk("tdo_en",     tap.tdo_en,     !rst && (m_st == 4 || m_st == 11));
            chk("tdo",        tap.tdo,        et);
        end
    end

    int cnt_cap, cnt_sh, cnt_upd, cnt_rd, cnt_en, cnt_bad;
    always @(negedge clk) begin
        if (tap.capture_dr) cnt_cap++;
        if (tap.shift_dr)   cnt_sh++;
        if (tap.update_dr)  cnt_upd++;
        if (tap.stat_read)  cnt_rd++;
        if (tap.tdo_en)     cnt_en++;
        if (tap.shift_dr && tap.tdo !== tap.stat_tdo) cnt_bad++;
    end

    task automatic clr_cnt();
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0; cnt_rd = 0; cnt_en = 0; cnt_bad = 0;
    endtask

    logic s_tdo, s_tdo_en, s_shift, s_strobes;

    task automatic tick(input logic en, input logic t, input logic d);
        tap.tck_en   = en;
        tap.tms      = t;
        tap.tdi      = d;
        tap.stat_tdo = 1'($urandom);
        tap.ctrl_tdo = 1'($urandom);
        @(negedge clk);
        s_tdo     = tap.tdo;
        s_tdo_en  = tap.tdo_en;
        s_shift   = tap.shift_dr;
        s_strobes = tap.capture_dr | tap.shift_dr | tap.update_dr | tap.stat_read;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic t, input logic d);
        repeat ($urandom_range(0, 1)) tick(1'b0, 1'($urandom), 1'($urandom));
        tick(1'b1, t, d);
    endtask

    task automatic load_ir(input logic [3:0] op);
        repeat (5) strobe(1'b1, 1'($urandom));
        strobe(1'b0, 1'($urandom));
        strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(i == 3, op[i]);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int n);
        strobe(1'b1, 1'($urandom)); strobe(1'b0, 1'($urandom)); strobe(1'b0, 1'($urandom));
        for (int i = 0; i < n; i++) strobe(i == n - 1, 1'($urandom));
        strobe(1'b1, 1'($urandom));
        strobe(1'b0, 1'($urandom));
    endtask

    initial begin
        logic [3:0] seq;
        logic [3:0] ir_hold;
        logic [3:0] bits;
        tap.tck_en = 1'b0; tap.tms = 1'b0; tap.tdi = 1'b0;
        tap.stat_tdo = 1'b0; tap.ctrl_tdo = 1'b0;
        clr_cnt();
        @(posedge clk); #1;

        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        chk("rst_strobes", s_strobes, 1'b0);
        chk("rst_tdo_en",  s_tdo_en,  1'b0);
        rst = 1'b0;
        checking = 1'b1;
        chk("rst_ir", tap.ir, 4'hF);

        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
        bits = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            strobe(i == 3, bits[i]);
            seq[i] = s_tdo;
        end
        chk("ir_shift_tdo", seq, 4'b0001);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        chk("ir_load_stat", tap.ir, 4'h2);
        chk("sel_stat_set", tap.sel_stat, 1'b1);

        clr_cnt();
        dr_scan(16);
        chk("scan_capture", cnt_cap, 1);
        chk("scan_shift",   cnt_sh, 16);
        chk("scan_update",  cnt_upd, 1);
        chk("scan_read",    cnt_rd, 1);
        chk("scan_tdo_eq",  cnt_bad, 0);

        strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
        clr_cnt();
        ir_hold = tap.ir;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'(i % 2), 1'($urandom));
        chk("idle_strobes", cnt_cap + cnt_sh + cnt_upd + cnt_rd, 0);
        chk("idle_tdo_en",  cnt_en, 10);
        chk("idle_ir",      tap.ir, ir_hold);
        strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);

        load_ir(4'h3);
        chk("ir_load_ctrl", tap.ir, 4'h3);
        chk("sel_ctrl_set", tap.sel_ctrl, 1'b1);
        repeat (5) strobe(1'b1, 1'b0);
        chk("tlr5_ir",  tap.ir, 4'hF);
        chk("tlr5_sel", tap.sel_ctrl, 1'b0);

        load_ir(4'h3);
        strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b1); strobe(1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b1, 1'b0, 1'b1);
        chk("midrst_shift", s_shift, 1'b0);
        rst = 1'b0;
        chk("midrst_ir",  tap.ir, 4'hF);
        chk("midrst_sel", tap.sel_ctrl, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("midrst_next_shift", s_shift, 1'b0);

        for (int it = 0; it < 60; it++) begin
            int k;
            logic [3:0] op;
            k  = $urandom_range(0, 2);
            op = (k == 0) ? 4'h2 : (k == 1) ? 4'h3 : 4'($urandom);
            load_ir(op);
            dr_scan($urandom_range(1, 20));
            for (int j = 0; j < 20; j++) begin
                rst = ($urandom_range(0, 49) == 0);
                tick(1'($urandom), 1'($urandom), 1'($urandom));
            end
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pm_tap_ctrl.md
PM_TAP_CTRL -- requirements
Module: pm_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_LENGTH, default 4, instruction register width (minimum 2).
REQ-002 SHALL have parameter STAT_OPCODE, default 4'h2, instruction selecting the status data register.
REQ-003 SHALL have parameter CTRL_OPCODE, default 4'h3, instruction selecting the control data register.
REQ-004 SHALL have port clk  input  1  the single clock for all state.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-006 SHALL have port tck_en  input  1  one-clk strobe marking a TCK rising edge; all TAP state advances only when it is 1.
REQ-007 SHALL have port tms  input  1  test mode select, sampled when tck_en=1.
REQ-008 SHALL have port tdi  input  1  test data in, sampled when tck_en=1.
REQ-009 SHALL have port stat_tdo  input  1  serial output of the status data register.
REQ-010 SHALL have port ctrl_tdo  input  1  serial output of the control data register.
REQ-011 SHALL have ports capture_dr, shift_dr and update_dr  output  1 each  one-clk action strobes to the selected data register.
REQ-012 SHALL have port sel_stat  output  1  status data register selected.
REQ-013 SHALL have port sel_ctrl  output  1  control data register selected.
REQ-014 SHALL have port stat_read  output  1  one-clk pulse that tells the status register to latch its parallel read data.
REQ-015 SHALL have port ir  output  IR_LENGTH  current instruction.
REQ-016 SHALL have port tdo  output  1  serial data out.
REQ-017 SHALL have port tdo_en  output  1  tdo is valid.

Function
REQ-018 SHALL implement the 16-state IEEE 1149.1 TAP FSM: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
REQ-019 SHALL move from TLR to TLR on tms=1 and to RTI on tms=0.
REQ-020 SHALL move from RTI and UPD_x to SEL_DR on tms=1 and to RTI on tms=0.
REQ-021 SHALL move from SEL_DR to SEL_IR on tms=1 and to CAP_DR on tms=0.
REQ-022 SHALL move from SEL_IR to TLR on tms=1 and to CAP_IR on tms=0.
REQ-023 SHALL move from CAP_x and SH_x to EX1_x on tms=1 and to SH_x on tms=0.
REQ-024 SHALL move from EX1_x to UPD_x on tms=1 and to PA_x on tms=0.
REQ-025 SHALL move from PA_x to EX2_x on tms=1 and stay in PA_x on tms=0.
REQ-026 SHALL move from EX2_x to UPD_x on tms=1 and to SH_x on tms=0.
REQ-027 SHALL change state only on clk edges where tck_en=1; when tck_en=0 state, IR and bypass SHALL hold.
REQ-028 SHALL assert capture_dr = (state==CAP_DR) and tck_en and (sel_stat or sel_ctrl), combinationally, so at most one pulse per TCK.
REQ-029 SHALL assert shift_dr = (state==SH_DR) and tck_en and (sel_stat or sel_ctrl), combinationally.
REQ-030 SHALL assert update_dr = (state==UPD_DR) and tck_en and (sel_stat or sel_ctrl), combinationally.
REQ-031 SHALL assert stat_read = (state==UPD_DR) and tck_en and sel_stat.
REQ-032 SHALL keep an IR shift register: in CAP_IR load {0..0,2'b01}; in SH_IR shift right with tdi entering the MSB.
REQ-033 SHALL copy the IR shift register to ir in UPD_IR (on tck_en=1); ir SHALL otherwise hold.
REQ-034 SHALL set ir to all ones (BYPASS) whenever the state is TLR.
REQ-035 SHALL drive sel_stat = (ir==STAT_OPCODE) and sel_ctrl = (ir==CTRL_OPCODE) combinationally; any other opcode selects bypass.
REQ-036 SHALL keep a 1-bit bypass register: cleared in CAP_DR, loaded with tdi in SH_DR, both only when bypass is selected and tck_en=1.
REQ-037 SHALL drive tdo as IR shift register bit 0 in SH_IR; in SH_DR as stat_tdo, ctrl_tdo or the bypass bit according to the selection; 0 otherwise.
REQ-038 SHALL drive tdo_en = 1 exactly in SH_IR and SH_DR.
REQ-039 SHALL reach TLR from any state after 5 consecutive tck_en strobes with tms=1.

Reset
REQ-040 SHALL, on clk with rst=1 and regardless of tck_en, set the state to TLR, ir and the IR shift register to all ones, and the bypass bit to 0.
REQ-041 SHALL hold all strobes, tdo and tdo_en at 0 while rst=1, including when rst is asserted mid-scan.

Verification
REQ-042 Bench SHALL cover: rst=1 for 1 clk -> state TLR, ir=4'hF, all strobes 0, tdo_en=0.
REQ-043 Bench SHALL cover: from RTI, 5 tck_en strobes with tms=1 -> TLR at the 5th strobe, ir=4'hF.
REQ-044 Bench SHALL cover: tms 1,1,0,0 then shift tdi 0,1,0,0 with tms=1 on the last bit, then 1 -> UPD_IR, ir=4'h2, sel_stat=1, tdo shows 1,0,0,0 during the shift.
REQ-045 Bench SHALL cover: with STAT selected, a 16-bit DR scan -> exactly 1 capture_dr, 16 shift_dr and 1 update_dr pulses, 1 stat_read pulse, and tdo equal to stat_tdo throughout.
REQ-046 Bench SHALL cover: tck_en=0 for 10 clk with tms toggling -> no state change and no strobes.
REQ-047 Bench SHALL cover: rst asserted in SH_DR with ir=CTRL_OPCODE -> shift_dr=0 next clk, state TLR, ir=4'hF, sel_ctrl=0.
